// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the execute-stage ALU slice: ALUop values, R-type
// funct codes, 4-bit ALU operation codes, status-bit positions and the
// ID-stage forward-select codes.
package alu_exec_unit_pkg;

  localparam int WIDTH     = 32;
  localparam int REGADDR_W = 5;
  localparam int STATUS_W  = 8;

  // ALUop from the main control unit
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  // R-type funct field values understood by the decoder
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;

  // Decoded ALU operation
  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SUB     = 4'b0110,
    ALU_SLT     = 4'b0111,
    ALU_SLL     = 4'b1000,
    ALU_SRL     = 4'b1001,
    ALU_SRA     = 4'b1010,
    ALU_NOR     = 4'b1100,
    ALU_INVALID = 4'b1111
  } alu_ctrl_e;

  // Bit positions inside the 8-bit status vector
  localparam int STAT_ZERO     = 0;
  localparam int STAT_NEGATIVE = 1;
  localparam int STAT_OVERFLOW = 2;
  localparam int STAT_CARRY    = 3;
  localparam int STAT_INVALID  = 4;

  // Forward select for the ID-stage branch comparator
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EX   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Bundle of the execute-unit operand, control, hazard and result signals.
// The master side is whoever drives the operands (pipeline or bench), the
// slave side is the execute unit itself.
interface alu_exec_unit_if;
  import alu_exec_unit_pkg::*;

  logic                 en;
  logic [1:0]           alu_op;
  logic [5:0]           funct;
  logic [4:0]           shamt;
  logic [WIDTH-1:0]     src_a;
  logic [WIDTH-1:0]     src_b;
  logic                 id_ex_regwrite;
  logic                 ex_mem_regwrite;
  logic [REGADDR_W-1:0] id_ex_rd;
  logic [REGADDR_W-1:0] ex_mem_rd;
  logic [REGADDR_W-1:0] if_id_rs;
  logic [REGADDR_W-1:0] if_id_rt;

  logic [3:0]           alu_ctrl;
  logic [WIDTH-1:0]     alu_result;
  logic [STATUS_W-1:0]  alu_status;
  logic [1:0]           f1;
  logic [1:0]           f2;
  logic [WIDTH-1:0]     alu_result_q;
  logic [STATUS_W-1:0]  alu_status_q;

  modport master (
    output en, alu_op, funct, shamt, src_a, src_b,
           id_ex_regwrite, ex_mem_regwrite, id_ex_rd, ex_mem_rd,
           if_id_rs, if_id_rt,
    input  alu_ctrl, alu_result, alu_status, f1, f2,
           alu_result_q, alu_status_q
  );

  modport slave (
    input  en, alu_op, funct, shamt, src_a, src_b,
           id_ex_regwrite, ex_mem_regwrite, id_ex_rd, ex_mem_rd,
           if_id_rs, if_id_rt,
    output alu_ctrl, alu_result, alu_status, f1, f2,
           alu_result_q, alu_status_q
  );

endinterface

// File: rtl/alu_exec_unit_branch_fwd_sel.sv
// Forwarding selector for the ID-stage branch comparator. Each ID source
// register is matched against the EX and MEM destinations; the younger EX
// producer wins, and register 0 is never forwarded.
module branch_fwd_sel
  import alu_exec_unit_pkg::*;
#(
  parameter int REGADDR_W = 5
) (
  input  logic                 id_ex_regwrite_i,
  input  logic                 ex_mem_regwrite_i,
  input  logic [REGADDR_W-1:0] id_ex_rd_i,
  input  logic [REGADDR_W-1:0] ex_mem_rd_i,
  input  logic [REGADDR_W-1:0] if_id_rs_i,
  input  logic [REGADDR_W-1:0] if_id_rt_i,
  output logic [1:0]           f1_o,
  output logic [1:0]           f2_o
);

  logic ex_valid;
  logic mem_valid;

  // A producer only counts if it writes a real (non-zero) register
  assign ex_valid  = id_ex_regwrite_i  && (id_ex_rd_i  != '0);
  assign mem_valid = ex_mem_regwrite_i && (ex_mem_rd_i != '0);

  // Priority select per source operand: EX match first, then MEM, else none
  always_comb begin
    f1_o = FWD_NONE;
    f2_o = FWD_NONE;
    if (ex_valid && (id_ex_rd_i == if_id_rs_i)) begin
      f1_o = FWD_EX;
    end else if (mem_valid && (ex_mem_rd_i == if_id_rs_i)) begin
      f1_o = FWD_MEM;
    end
    if (ex_valid && (id_ex_rd_i == if_id_rt_i)) begin
      f2_o = FWD_EX;
    end else if (mem_valid && (ex_mem_rd_i == if_id_rt_i)) begin
      f2_o = FWD_MEM;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage core: ALU-control decode, 32-bit ALU with status flags,
// the ID branch forwarding selector, and the EX/MEM result register.
// Decode, ALU and forwarding are combinational so forwarding and branch
// logic can use them in the same cycle.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REGADDR_W = 5
) (
  input logic           clk,
  input logic           reset,
  alu_exec_unit_if.slave bus
);

  alu_ctrl_e            ctrl;
  logic [WIDTH-1:0]     result;
  logic                 ovf;
  logic                 carry;
  logic                 invalid;
  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic [STATUS_W-1:0]  status;
  logic [WIDTH-1:0]     result_d;
  logic [WIDTH-1:0]     result_q;
  logic [STATUS_W-1:0]  status_d;
  logic [STATUS_W-1:0]  status_q;

  // ALU-control decode: ALUop picks a fixed op, or defers to funct for R-type
  always_comb begin
    ctrl = ALU_INVALID;
    case (bus.alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_OR:  ctrl = ALU_OR;
      default: begin
        case (bus.funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl = ALU_SUB;
          FUNCT_AND:             ctrl = ALU_AND;
          FUNCT_OR:              ctrl = ALU_OR;
          FUNCT_XOR:             ctrl = ALU_XOR;
          FUNCT_NOR:             ctrl = ALU_NOR;
          FUNCT_SLT:             ctrl = ALU_SLT;
          FUNCT_SLL:             ctrl = ALU_SLL;
          FUNCT_SRL:             ctrl = ALU_SRL;
          FUNCT_SRA:             ctrl = ALU_SRA;
          default:               ctrl = ALU_INVALID;
        endcase
      end
    endcase
  end

  // One extra bit on both adders exposes carry-out and unsigned borrow
  assign add_full = {1'b0, bus.src_a} + {1'b0, bus.src_b};
  assign sub_full = {1'b0, bus.src_a} - {1'b0, bus.src_b};

  // ALU datapath; overflow/carry only meaningful for ADD and SUB
  always_comb begin
    result  = '0;
    ovf     = 1'b0;
    carry   = 1'b0;
    invalid = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        result = add_full[WIDTH-1:0];
        carry  = add_full[WIDTH];
        ovf    = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                 (result[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = sub_full[WIDTH-1:0];
        carry  = sub_full[WIDTH];
        ovf    = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                 (result[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      ALU_AND: result = bus.src_a & bus.src_b;
      ALU_OR:  result = bus.src_a | bus.src_b;
      ALU_XOR: result = bus.src_a ^ bus.src_b;
      ALU_NOR: result = ~(bus.src_a | bus.src_b);
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      ALU_SLL: result = bus.src_b << bus.shamt;
      ALU_SRL: result = bus.src_b >> bus.shamt;
      ALU_SRA: result = $signed(bus.src_b) >>> bus.shamt;
      default: invalid = 1'b1;
    endcase
  end

  // Pack the status flags; upper bits are reserved as zero
  always_comb begin
    status                = '0;
    status[STAT_ZERO]     = (result == '0);
    status[STAT_NEGATIVE] = result[WIDTH-1];
    status[STAT_OVERFLOW] = ovf;
    status[STAT_CARRY]    = carry;
    status[STAT_INVALID]  = invalid;
  end

  branch_fwd_sel #(
    .REGADDR_W(REGADDR_W)
  ) u_fwd (
    .id_ex_regwrite_i (bus.id_ex_regwrite),
    .ex_mem_regwrite_i(bus.ex_mem_regwrite),
    .id_ex_rd_i       (bus.id_ex_rd),
    .ex_mem_rd_i      (bus.ex_mem_rd),
    .if_id_rs_i       (bus.if_id_rs),
    .if_id_rt_i       (bus.if_id_rt),
    .f1_o             (bus.f1),
    .f2_o             (bus.f2)
  );

  // Next state of the EX/MEM copy: capture when enabled, hold on stall
  always_comb begin
    result_d = result_q;
    status_d = status_q;
    if (bus.en) begin
      result_d = result;
      status_d = status;
    end
  end

  // EX/MEM register with synchronous reset taking priority over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      status_q <= '0;
    end else begin
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign bus.alu_ctrl     = ctrl;
  assign bus.alu_result   = result;
  assign bus.alu_status   = status;
  assign bus.alu_result_q = result_q;
  assign bus.alu_status_q = status_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases from the test plan
// followed by randomized operations checked against an arithmetic model.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] exp_res_q;
  logic [7:0]  exp_stat_q;

  logic [5:0]  valid_funct [12] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                    6'b101010, 6'b000000, 6'b000010, 6'b000011};
  logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000,
                              32'hFFFFFFFF, 32'h00000005};

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decode and evaluate from the instruction semantics
  task automatic refAlu(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [3:0] ctrl, output logic [31:0] res,
                        output logic [7:0] st);
    longint ua, ub, sa, sb, wide, pw;
    logic ov, cy, inv;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    pw = longint'(1) << sh;
    ov = 1'b0;
    cy = 1'b0;
    inv = 1'b0;
    res = 32'h0;
    if (op == 2'b00) ctrl = 4'b0010;
    else if (op == 2'b01) ctrl = 4'b0110;
    else if (op == 2'b11) ctrl = 4'b0001;
    else begin
      case (fn)
        6'b100000, 6'b100001: ctrl = 4'b0010;
        6'b100010, 6'b100011: ctrl = 4'b0110;
        6'b100100: ctrl = 4'b0000;
        6'b100101: ctrl = 4'b0001;
        6'b100110: ctrl = 4'b0011;
        6'b100111: ctrl = 4'b1100;
        6'b101010: ctrl = 4'b0111;
        6'b000000: ctrl = 4'b1000;
        6'b000010: ctrl = 4'b1001;
        6'b000011: ctrl = 4'b1010;
        default:   ctrl = 4'b1111;
      endcase
    end
    case (ctrl)
      4'b0010: begin
        wide = ua + ub;
        res  = wide[31:0];
        cy   = (wide > 64'hFFFFFFFF);
        wide = sa + sb;
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0110: begin
        wide = ua - ub;
        res  = wide[31:0];
        cy   = (ua < ub);
        wide = sa - sb;
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0011: res = a ^ b;
      4'b1100: res = ~(a | b);
      4'b0111: res = (sa < sb) ? 32'h1 : 32'h0;
      4'b1000: begin wide = ub * pw; res = wide[31:0]; end
      4'b1001: begin wide = ub / pw; res = wide[31:0]; end
      4'b1010: begin wide = sb >>> sh; res = wide[31:0]; end
      default: inv = 1'b1;
    endcase
    st = {3'b000, inv, cy, ov, res[31], (res == 32'h0)};
  endtask

  // Reference forwarding choice for one ID source register
  function automatic logic [1:0] refFwd(input logic [4:0] src);
    if (bus.id_ex_regwrite && bus.id_ex_rd != 5'd0 && bus.id_ex_rd == src) return 2'b01;
    if (bus.ex_mem_regwrite && bus.ex_mem_rd != 5'd0 && bus.ex_mem_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                               input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.funct  = fn;
    bus.shamt  = sh;
    bus.src_a  = a;
    bus.src_b  = b;
    #1;
  endtask

  task automatic applyFwd(input logic idw, input logic [4:0] idrd, input logic memw,
                          input logic [4:0] memrd, input logic [4:0] rs, input logic [4:0] rt);
    bus.id_ex_regwrite  = idw;
    bus.id_ex_rd        = idrd;
    bus.ex_mem_regwrite = memw;
    bus.ex_mem_rd       = memrd;
    bus.if_id_rs        = rs;
    bus.if_id_rt        = rt;
    #1;
  endtask

  // Compare every combinational output against the model
  task automatic checkComb(input string tag);
    logic [3:0] c;
    logic [31:0] r;
    logic [7:0] s;
    refAlu(bus.alu_op, bus.funct, bus.shamt, bus.src_a, bus.src_b, c, r, s);
    checkOutput({tag, "_ctrl"}, {28'h0, bus.alu_ctrl}, {28'h0, c});
    checkOutput({tag, "_res"}, bus.alu_result, r);
    checkOutput({tag, "_stat"}, {24'h0, bus.alu_status}, {24'h0, s});
    checkOutput({tag, "_f1"}, {30'h0, bus.f1}, {30'h0, refFwd(bus.if_id_rs)});
    checkOutput({tag, "_f2"}, {30'h0, bus.f2}, {30'h0, refFwd(bus.if_id_rt)});
  endtask

  // Advance one clock and update the model of the registered outputs
  task automatic tick();
    logic [3:0] c;
    logic [31:0] r;
    logic [7:0] s;
    refAlu(bus.alu_op, bus.funct, bus.shamt, bus.src_a, bus.src_b, c, r, s);
    @(posedge clk);
    if (reset) begin
      exp_res_q  = 32'h0;
      exp_stat_q = 8'h0;
    end else if (bus.en) begin
      exp_res_q  = r;
      exp_stat_q = s;
    end
    #1;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_res_q"}, bus.alu_result_q, exp_res_q);
    checkOutput({tag, "_stat_q"}, {24'h0, bus.alu_status_q}, {24'h0, exp_stat_q});
  endtask

  initial begin
    logic [31:0] a, b;
    logic [5:0] fn;
    total = 0;
    bad = 0;
    exp_res_q = 32'h0;
    exp_stat_q = 8'h0;
    reset = 1'b1;
    bus.en = 1'b0;
    applyFwd(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    applyStimulus(2'b00, 6'd0, 5'd0, 32'h0, 32'h0);
    tick();
    checkOutput("reset_res_q", bus.alu_result_q, 32'h0);
    checkOutput("reset_stat_q", {24'h0, bus.alu_status_q}, 32'h0);
    reset = 1'b0;
    bus.en = 1'b1;

    $display("[TB] directed ALU cases");
    applyStimulus(2'b10, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1);
    checkOutput("add_ovf_ctrl", {28'h0, bus.alu_ctrl}, 32'h2);
    checkOutput("add_ovf_res", bus.alu_result, 32'h80000000);
    checkOutput("add_ovf_stat", {24'h0, bus.alu_status}, 32'h06);
    checkComb("add_ovf");
    tick();
    checkOutput("add_ovf_q", bus.alu_result_q, 32'h80000000);
    checkRegs("add_ovf");

    applyStimulus(2'b01, 6'd0, 5'd0, 32'd5, 32'd5);
    checkOutput("sub_eq_res", bus.alu_result, 32'h0);
    checkOutput("sub_eq_stat", {24'h0, bus.alu_status}, 32'h01);
    applyStimulus(2'b01, 6'd0, 5'd0, 32'd3, 32'd5);
    checkOutput("sub_lt_res", bus.alu_result, 32'hFFFFFFFE);
    checkOutput("sub_lt_stat", {24'h0, bus.alu_status}, 32'h0A);
    checkComb("sub_lt");

    applyStimulus(2'b10, 6'b000011, 5'd4, 32'h12345678, 32'h80000000);
    checkOutput("sra_res", bus.alu_result, 32'hF8000000);
    applyStimulus(2'b10, 6'b000010, 5'd4, 32'h12345678, 32'h80000000);
    checkOutput("srl_res", bus.alu_result, 32'h08000000);
    applyStimulus(2'b10, 6'b000000, 5'd0, 32'h0, 32'hDEADBEEF);
    checkOutput("sll0_res", bus.alu_result, 32'hDEADBEEF);
    applyStimulus(2'b10, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'h1);
    checkOutput("slt_res", bus.alu_result, 32'h1);
    applyStimulus(2'b10, 6'b111111, 5'd0, 32'h5, 32'h7);
    checkOutput("inv_ctrl", {28'h0, bus.alu_ctrl}, 32'hF);
    checkOutput("inv_res", bus.alu_result, 32'h0);
    checkOutput("inv_stat", {24'h0, bus.alu_status}, 32'h11);
    applyStimulus(2'b11, 6'b000000, 5'd0, 32'hF0F00000, 32'h0000ABCD);
    checkOutput("ori_res", bus.alu_result, 32'hF0F0ABCD);

    $display("[TB] directed forwarding cases");
    applyFwd(1'b1, 5'd8, 1'b1, 5'd8, 5'd8, 5'd9);
    checkOutput("fwd_ex_prio_f1", {30'h0, bus.f1}, 32'h1);
    checkOutput("fwd_ex_prio_f2", {30'h0, bus.f2}, 32'h0);
    applyFwd(1'b0, 5'd8, 1'b1, 5'd9, 5'd8, 5'd9);
    checkOutput("fwd_mem_f2", {30'h0, bus.f2}, 32'h2);
    checkOutput("fwd_mem_f1", {30'h0, bus.f1}, 32'h0);
    applyFwd(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("fwd_r0_f1", {30'h0, bus.f1}, 32'h0);
    checkOutput("fwd_r0_f2", {30'h0, bus.f2}, 32'h0);
    applyFwd(1'b0, 5'd8, 1'b0, 5'd9, 5'd8, 5'd9);
    checkOutput("fwd_nowr_f1", {30'h0, bus.f1}, 32'h0);
    checkOutput("fwd_nowr_f2", {30'h0, bus.f2}, 32'h0);

    $display("[TB] hold and reset");
    bus.en = 1'b1;
    applyStimulus(2'b00, 6'd0, 5'd0, 32'd100, 32'd23);
    tick();
    checkOutput("load_q", bus.alu_result_q, 32'd123);
    bus.en = 1'b0;
    applyStimulus(2'b00, 6'd0, 5'd0, 32'd1, 32'd1);
    tick();
    checkOutput("hold_q", bus.alu_result_q, 32'd123);
    checkOutput("hold_stat_q", {24'h0, bus.alu_status_q}, 32'h0);
    reset = 1'b1;
    bus.en = 1'b1;
    tick();
    checkOutput("rst_en_q", bus.alu_result_q, 32'h0);
    checkOutput("rst_en_stat_q", {24'h0, bus.alu_status_q}, 32'h0);
    reset = 1'b0;

    $display("[TB] randomized sequence");
    for (int i = 0; i < 300; i++) begin
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                       : valid_funct[$urandom_range(0, 11)];
      a = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      b = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      bus.en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 15) == 0);
      applyFwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      applyStimulus(2'($urandom_range(0, 3)), fn, 5'($urandom_range(0, 31)), a, b);
      checkComb("rnd");
      tick();
      checkRegs("rnd");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage datapath core of the 5-stage MIPS-style pipeline. Contains three parts:
- ALU-control decode: ALUop plus funct to a 4-bit operation code.
- The 32-bit ALU, with an 8-bit status vector.
- The ID-stage branch-compare forwarding selector.

Combinational results feed forwarding and branch logic in the same cycle. A registered copy of the result and status feeds the EX/MEM boundary.

Parameters:
- WIDTH, 32, datapath width (only 32 is supported).
- REGADDR_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all registers
- en  in  1  register-update enable; 0 holds the registered outputs (stall)
- alu_op  in  2  ALUop from main control
- funct  in  6  instruction[5:0]
- shamt  in  5  instruction[10:6]
- src_a  in  32  operand A (rs, already forwarded)
- src_b  in  32  operand B (rt or sign-extended immediate)
- id_ex_regwrite  in  1  RegWrite of the instruction in EX
- ex_mem_regwrite  in  1  RegWrite of the instruction in MEM
- id_ex_rd  in  5  destination register of the instruction in EX
- ex_mem_rd  in  5  destination register of the instruction in MEM
- if_id_rs  in  5  rs of the instruction in ID
- if_id_rt  in  5  rt of the instruction in ID
- alu_ctrl  out  4  decoded operation
- alu_result  out  32  combinational result
- alu_status  out  8  combinational status
- f1  out  2  forward select for the ID rs comparator
- f2  out  2  forward select for the ID rt comparator
- alu_result_q  out  32  registered result
- alu_status_q  out  8  registered status

Behaviour:
ALU-control decode, by alu_op:
- 00 -> ADD (0010). Used by lw, sw, addi.
- 01 -> SUB (0110). Used by beq.
- 11 -> OR (0001). Used by ori.
- 10 -> decode funct:
  - 100000 and 100001 -> ADD 0010
  - 100010 and 100011 -> SUB 0110
  - 100100 -> AND 0000
  - 100101 -> OR 0001
  - 100110 -> XOR 0011
  - 100111 -> NOR 1100
  - 101010 -> SLT 0111
  - 000000 -> SLL 1000
  - 000010 -> SRL 1001
  - 000011 -> SRA 1010
  - any other funct -> INVALID 1111

ALU operations:
- ADD and SUB: two's-complement, 32-bit wrap-around.
- SLT: result is 1 if src_a < src_b as signed values, else 0.
- Shifts: shift src_b by shamt. src_a is ignored. SRA replicates bit 31. shamt = 0 passes src_b unchanged.
- INVALID: result is 0.

alu_status bits:
- [0] zero: result == 0.
- [1] negative: result[31].
- [2] signed overflow. ADD: operands have the same sign and the result sign differs. SUB: operands have different signs and the result sign differs from src_a. 0 for all other operations.
- [3] carry/borrow-out. ADD: carry out of bit 31. SUB: set when src_a < src_b unsigned. 0 for all other operations.
- [4] invalid op.
- [7:5] always 0.

Overflow policy:
- The result is still produced on overflow.
- Suppressing the writeback is the downstream exception block's job.
- addu and subu set overflow the same way as add and sub; the downstream block ignores it for them.

Forwarding (f1 from if_id_rs, f2 from if_id_rt):
- 01: id_ex_regwrite && id_ex_rd != 0 && id_ex_rd == the ID source register.
- 10: otherwise, if ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == the ID source register.
- 00: otherwise.
- The EX match has priority over the MEM match.
- Register 0 never forwards.
- 11 is never produced.

Timing:
- alu_ctrl, alu_result, alu_status, f1 and f2 are purely combinational, with zero latency.
- On each rising clk edge:
  - reset=1: alu_result_q=0, alu_status_q=0.
  - else if en=1: they capture alu_result and alu_status.
  - else: they hold.
- reset has priority over en.
- Latency of the registered outputs is 1 cycle.

Decomposition:
- Shared package: the ALUop encodings, the funct codes, the 4-bit ALU operation codes, the status-bit indices, and the forward-select codes FWD_NONE=00, FWD_EX=01, FWD_MEM=10.
- One natural sub-module, branch_fwd_sel, holding the forwarding comparator. The decode and the ALU stay in the top module.

Test Plan:
- alu_op=10, funct=100000, A=0x7FFFFFFF, B=1 -> alu_ctrl=0010, result 0x80000000, status overflow=1, negative=1, zero=0. Next edge with en=1 -> alu_result_q=0x80000000.
- alu_op=01, A=5, B=5 -> result 0, zero=1, carry=0. A=3, B=5 -> result 0xFFFFFFFE, carry (borrow)=1, negative=1.
- alu_op=10, funct=000011, shamt=4, B=0x80000000 -> result 0xF8000000. Same with funct=000010 (SRL) -> 0x08000000. funct=101010, A=-1, B=1 -> result 1.
- alu_op=10, funct=111111 -> alu_ctrl=1111, result 0, status[4]=1.
- Forwarding, with if_id_rs=8 and if_id_rt=9:
  - id_ex_rd=8, ex_mem_rd=8, both regwrite=1 -> f1=01.
  - ex_mem_rd=9, ex_mem_regwrite=1 -> f2=10.
  - Any rd=0, or regwrite=0 -> f1/f2=00.
- Hold and reset: load a result with en=1, then set en=0 and change the inputs -> the q outputs hold. Assert reset together with en=1 -> both q outputs are 0 at the next edge.
